dvp_cam_tx: RTL and testbench
=============================

Name: dvp_cam_tx

Overview:
- Camera-side DVP transmitter; the counterpart of the camera capture path (vsync/href/pclk/8-bit data).
- Takes an RGB565 pixel stream on a valid/ready handshake and drives OV-style DVP timing: two bytes per pixel, high byte first.
- Used as a camera emulator for simulation and loopback, and to drive the capture/sobel chain from a test-pattern source on board.

Parameters:
- H_ACTIVE, 640, active pixels per line; each line carries 2*H_ACTIVE bytes.
- V_ACTIVE, 480, active lines per frame.
- H_BLANK, 144, pclk periods with href low after each active line.
- VSYNC_LINES, 3, line periods with vsync high.
- V_BP_LINES, 17, blank line periods between vsync falling and the first active line.
- V_FP_LINES, 10, blank line periods after the last active line.

Ports:
- sys_clk_i  in  1  system clock; the only clock.
- sys_rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  start and continue frames; sampled only at frame boundaries.
- s_data_i  in  16  RGB565 pixel.
- s_valid_i  in  1  s_data_i valid.
- s_ready_o  out  1  pixel consumed this cycle.
- pclk_o  out  1  DVP pixel clock, sys_clk/2.
- vsync_o  out  1  DVP vsync, active high.
- href_o  out  1  DVP href, active high.
- cam_data_o  out  8  DVP data byte.
- frame_start_o  out  1  one-cycle pulse when vsync rises.
- underrun_o  out  1  sticky: a pixel was needed while s_valid_i was low.
- busy_o  out  1  high while a frame is in progress.

Behaviour:
- Reset: the cycle after sys_rst_i is high, every output is 0 (pclk_o, vsync_o, href_o, cam_data_o, s_ready_o, frame_start_o, underrun_o, busy_o). All counters clear and the FSM returns to IDLE.
- Reset mid-frame aborts the frame with no completion; the next frame starts from VSYNC.
- Phase bit ph toggles every sys clock while not in IDLE; pclk_o = ph.
- A "launch" is the cycle where ph goes 1->0. At each launch, vsync_o, href_o and cam_data_o update together. They are therefore stable across the following pclk rising edge, which is where the receiver samples.
- In IDLE, ph is held at 0 and pclk_o stays low.
- Line period = 2*H_ACTIVE + H_BLANK pclk periods. A pixel-column counter and a line counter advance at launches.
- FSM:
  - IDLE: if enable_i=1, go to VSYNC and pulse frame_start_o for one cycle. busy_o=1 in every state except IDLE.
  - VSYNC: vsync_o=1, href_o=0 for VSYNC_LINES line periods, then V_BP.
  - V_BP: both low for V_BP_LINES line periods, then ACTIVE.
  - ACTIVE: for each line, href_o=1 for 2*H_ACTIVE launches, then 0 for H_BLANK launches. Repeats for V_ACTIVE lines, then V_FP.
  - V_FP: both low for V_FP_LINES line periods, then IDLE if enable_i=0, else directly VSYNC with a frame_start_o pulse. There is no IDLE cycle between frames, so back-to-back frames are gapless.
- Deasserting enable_i mid-frame has no effect until the end of V_FP.
- Handshake:
  - s_ready_o is 1 for exactly one sys cycle: the launch cycle of each high byte, H_ACTIVE times per active line. It is combinational from FSM state, ph and byte select, not from s_valid_i.
  - Transfer happens when s_valid_i=1 on that cycle. cam_data_o takes s_data_i[15:8] and s_data_i[7:0] is held for the next launch.
  - If s_valid_i=0 at that cycle, both bytes are 0x00 and underrun_o sets. underrun_o clears only on reset.
- cam_data_o = 0x00 whenever href_o=0.
- Byte select toggles per launch inside href and is forced to high byte at each line start.

Decomposition:
- Package dvp_pkg holds:
  - FSM state enum (IDLE, VSYNC, V_BP, ACTIVE, V_FP).
  - Localparam helpers: LINE_LEN = 2*H_ACTIVE+H_BLANK, and counter widths via $clog2.
- Natural sub-module: dvp_line_timer. It holds the column counter, href generation and the end-of-line pulse. The top keeps the FSM, line counter and the pixel/byte datapath.

Test Plan (H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, VSYNC_LINES=1, V_BP_LINES=1, V_FP_LINES=1):
- Timing: enable_i=1, s_valid_i=1 continuously.
  - Expect vsync high 11 pclk periods, then 11 blank, then per line href high 8 and low 3, then 11 blank.
  - Frame = 55 pclk = 110 sys cycles between frame_start_o pulses.
- Data order: pixels 0x1234, 0xABCD, 0x0F0F, 0xF0F0.
  - Expect receiver (sampling on pclk_o rising) to capture bytes 12 34 AB CD 0F 0F F0 F0 on line 0.
  - Expect s_ready_o pulsed 4 times per line.
- Underrun: drop s_valid_i at the 2nd pixel.
  - Expect bytes 12 34 00 00 ..., underrun_o=1 from then on.
  - Expect timing unchanged.
- Stop: drop enable_i during line 1 active.
  - Expect the frame to complete through V_FP, then IDLE with pclk_o=0 and busy_o=0, and no further frame_start_o.
- Reset mid-frame: assert sys_rst_i during href.
  - Expect all outputs 0 the next cycle.
  - After release with enable_i=1, expect a fresh frame_start_o and a full 110-cycle frame.
- Back-to-back: enable_i held high for 3 frames.
  - Expect frame_start_o exactly every 110 sys cycles and vsync rising directly after V_FP with no gap.

Source files
------------

// File: rtl/dvp_pkg.sv
// Shared state encoding and sizing helpers for the DVP camera transmitter.
package dvp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VSYNC,
      ST_V_BP,
      ST_ACTIVE,
      ST_V_FP
   } state_t;

   localparam int unsigned H_ACTIVE_DEF    = 640;
   localparam int unsigned V_ACTIVE_DEF    = 480;
   localparam int unsigned H_BLANK_DEF     = 144;
   localparam int unsigned VSYNC_LINES_DEF = 3;
   localparam int unsigned V_BP_LINES_DEF  = 17;
   localparam int unsigned V_FP_LINES_DEF  = 10;

   // Pclk periods per line: two bytes per pixel plus horizontal blanking.
   function automatic int unsigned line_len(input int unsigned h_active,
                                            input int unsigned h_blank);
      return 2 * h_active + h_blank;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/dvp_cam_tx_line_timer.sv
// Column counter for one line period; produces href and the end-of-line strobe.
module dvp_line_timer
   import dvp_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_BLANK  = H_BLANK_DEF
)(
   input  logic clk,
   input  logic srst,
   input  logic start,
   input  logic launch,
   input  logic active_next,
   output logic eol,
   output logic href_next,
   output logic href
);
   localparam int unsigned LINE_LEN = line_len(H_ACTIVE, H_BLANK);
   localparam int unsigned COL_W    = cnt_width(LINE_LEN);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);
   localparam logic [COL_W-1:0] HREF_END = COL_W'(2 * H_ACTIVE);

   logic [COL_W-1:0] col_reg;
   logic [COL_W-1:0] col_next;
   logic             href_reg;

   assign eol       = (col_reg == COL_LAST);
   assign col_next  = eol ? '0 : col_reg + COL_W'(1);
   // Evaluated for the period about to be launched, not the one on the wire.
   assign href_next = active_next && (col_next < HREF_END);
   assign href      = href_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         col_reg  <= '0;
         href_reg <= 1'b0;
      end else if (start) begin
         col_reg  <= '0;
         href_reg <= 1'b0;
      end else if (launch) begin
         col_reg  <= col_next;
         href_reg <= href_next;
      end
   end

endmodule

// File: rtl/dvp_cam_tx.sv
// Camera-side DVP transmitter: RGB565 valid/ready stream in, OV-style
// vsync/href/pclk/byte timing out, high byte first.
module dvp_cam_tx
   import dvp_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
   parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
   parameter int unsigned H_BLANK     = H_BLANK_DEF,
   parameter int unsigned VSYNC_LINES = VSYNC_LINES_DEF,
   parameter int unsigned V_BP_LINES  = V_BP_LINES_DEF,
   parameter int unsigned V_FP_LINES  = V_FP_LINES_DEF
)(
   input  logic        sys_clk_i,
   input  logic        sys_rst_i,
   input  logic        enable_i,
   input  logic [15:0] s_data_i,
   input  logic        s_valid_i,
   output logic        s_ready_o,
   output logic        pclk_o,
   output logic        vsync_o,
   output logic        href_o,
   output logic [7:0]  cam_data_o,
   output logic        frame_start_o,
   output logic        underrun_o,
   output logic        busy_o
);
   localparam int unsigned LINE_W =
      cnt_width(max4(VSYNC_LINES, V_BP_LINES, V_ACTIVE, V_FP_LINES));
   localparam logic [LINE_W-1:0] VS_LAST  = LINE_W'(VSYNC_LINES - 1);
   localparam logic [LINE_W-1:0] BP_LAST  = LINE_W'(V_BP_LINES - 1);
   localparam logic [LINE_W-1:0] ACT_LAST = LINE_W'(V_ACTIVE - 1);
   localparam logic [LINE_W-1:0] FP_LAST  = LINE_W'(V_FP_LINES - 1);

   state_t            state_reg, state_next;
   logic [LINE_W-1:0] line_reg, line_next, line_last;
   logic              ph_reg;
   logic              byte_sel_reg;   // 1: next launch inside href carries the low byte
   logic [7:0]        low_reg;
   logic [7:0]        data_reg;
   logic              vsync_reg;
   logic              fs_reg;
   logic              underrun_reg;

   logic start, launch, eol, href_next, href, active_next, frame_begin;

   assign start  = (state_reg == ST_IDLE) && enable_i;
   assign launch = (state_reg != ST_IDLE) && ph_reg;

   always_comb begin
      case (state_reg)
         ST_VSYNC:  line_last = VS_LAST;
         ST_V_BP:   line_last = BP_LAST;
         ST_ACTIVE: line_last = ACT_LAST;
         default:   line_last = FP_LAST;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      line_next  = line_reg;
      if (start) begin
         state_next = ST_VSYNC;
         line_next  = '0;
      end else if (launch && eol) begin
         if (line_reg == line_last) begin
            line_next = '0;
            case (state_reg)
               ST_VSYNC:  state_next = ST_V_BP;
               ST_V_BP:   state_next = ST_ACTIVE;
               ST_ACTIVE: state_next = ST_V_FP;
               ST_V_FP:   state_next = enable_i ? ST_VSYNC : ST_IDLE;
               default:   state_next = ST_IDLE;
            endcase
         end else begin
            line_next = line_reg + LINE_W'(1);
         end
      end
   end

   assign active_next = (state_next == ST_ACTIVE);
   // Covers both the IDLE start and the gapless V_FP -> VSYNC wrap.
   assign frame_begin = (state_next == ST_VSYNC) && (state_reg != ST_VSYNC);

   dvp_line_timer #(
      .H_ACTIVE (H_ACTIVE),
      .H_BLANK  (H_BLANK)
   ) u_line_timer (
      .clk         (sys_clk_i),
      .srst        (sys_rst_i),
      .start       (start),
      .launch      (launch),
      .active_next (active_next),
      .eol         (eol),
      .href_next   (href_next),
      .href        (href)
   );

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         state_reg    <= ST_IDLE;
         line_reg     <= '0;
         ph_reg       <= 1'b0;
         byte_sel_reg <= 1'b0;
         low_reg      <= 8'h00;
         data_reg     <= 8'h00;
         vsync_reg    <= 1'b0;
         fs_reg       <= 1'b0;
         underrun_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         line_reg  <= line_next;
         ph_reg    <= (state_reg == ST_IDLE) ? 1'b0 : ~ph_reg;
         fs_reg    <= frame_begin;
         if (start || launch) begin
            vsync_reg <= (state_next == ST_VSYNC);
         end
         if (launch) begin
            if (href_next) begin
               if (!byte_sel_reg) begin
                  // A missed pixel still occupies its slot so line timing never slips.
                  data_reg <= s_valid_i ? s_data_i[15:8] : 8'h00;
                  low_reg  <= s_valid_i ? s_data_i[7:0]  : 8'h00;
                  if (!s_valid_i) begin
                     underrun_reg <= 1'b1;
                  end
               end else begin
                  data_reg <= low_reg;
               end
               byte_sel_reg <= ~byte_sel_reg;
            end else begin
               data_reg     <= 8'h00;
               byte_sel_reg <= 1'b0;
            end
         end
      end
   end

   assign s_ready_o     = launch && href_next && !byte_sel_reg;
   assign pclk_o        = ph_reg;
   assign vsync_o       = vsync_reg;
   assign href_o        = href;
   assign cam_data_o    = data_reg;
   assign frame_start_o = fs_reg;
   assign underrun_o    = underrun_reg;
   assign busy_o        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dvp_cam_tx.sv
// Bench for dvp_cam_tx on a tiny raster: frame-time reference model checked
// every cycle, plus a pclk-edge receiver with hand-computed frame expectations.
module tb_dvp_cam_tx;
   localparam int HA  = 4;
   localparam int VA  = 2;
   localparam int HB  = 3;
   localparam int VS  = 1;
   localparam int VBP = 1;
   localparam int VFP = 1;
   localparam int LL  = 2 * HA + HB;
   localparam int FP  = (VS + VBP + VA + VFP) * LL;
   localparam int FC  = 2 * FP;

   logic        clk = 1'b0;
   logic        sys_rst_i = 1'b1;
   logic        enable_i = 1'b0;
   logic [15:0] s_data_i = 16'h0000;
   logic        s_valid_i = 1'b0;
   logic        s_ready_o, pclk_o, vsync_o, href_o, frame_start_o, underrun_o, busy_o;
   logic [7:0]  cam_data_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   dvp_cam_tx #(
      .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
      .VSYNC_LINES(VS), .V_BP_LINES(VBP), .V_FP_LINES(VFP)
   ) dut (
      .sys_clk_i     (clk),
      .sys_rst_i     (sys_rst_i),
      .enable_i      (enable_i),
      .s_data_i      (s_data_i),
      .s_valid_i     (s_valid_i),
      .s_ready_o     (s_ready_o),
      .pclk_o        (pclk_o),
      .vsync_o       (vsync_o),
      .href_o        (href_o),
      .cam_data_o    (cam_data_o),
      .frame_start_o (frame_start_o),
      .underrun_o    (underrun_o),
      .busy_o        (busy_o)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- reference model: position inside the frame ----------------
   bit         arm = 1'b0;
   bit         m_run = 1'b0;
   bit         m_unr = 1'b0;
   int         m_t = 0;
   logic [7:0] m_hi = 8'h00;
   logic [7:0] m_lo = 8'h00;

   function automatic bit in_href(input int p);
      int ln = p / LL;
      return (ln >= VS + VBP) && (ln < VS + VBP + VA) && ((p % LL) < 2 * HA);
   endfunction

   initial forever begin
      @(negedge clk);
      if (arm) begin : model_step
         bit e_pclk, e_vs, e_href, e_rdy, e_fs;
         logic [7:0] e_data;
         int p, np;
         p      = m_t / 2;
         np     = (m_t + 1) / 2;
         e_pclk = m_run && (m_t % 2 == 1);
         e_vs   = m_run && (p < VS * LL);
         e_href = m_run && in_href(p);
         e_data = !e_href ? 8'h00 : (((p % LL) % 2 == 0) ? m_hi : m_lo);
         e_rdy  = m_run && (m_t % 2 == 1) && (np < FP) && in_href(np) && ((np % LL) % 2 == 0);
         e_fs   = m_run && (m_t == 0);
         chk("pclk", pclk_o, e_pclk);
         chk("vsync", vsync_o, e_vs);
         chk("href", href_o, e_href);
         chk("data", cam_data_o, e_data);
         chk("ready", s_ready_o, e_rdy);
         chk("frame_start", frame_start_o, e_fs);
         chk("busy", busy_o, m_run);
         chk("underrun", underrun_o, m_unr);
         if (sys_rst_i) begin
            m_run = 1'b0; m_unr = 1'b0; m_hi = 8'h00; m_lo = 8'h00; m_t = 0;
         end else begin
            if (e_rdy) begin
               if (s_valid_i) begin
                  m_hi = s_data_i[15:8];
                  m_lo = s_data_i[7:0];
               end else begin
                  m_hi = 8'h00; m_lo = 8'h00; m_unr = 1'b1;
               end
            end
            if (m_run) begin
               if (m_t == FC - 1) begin
                  m_run = enable_i;
                  m_t   = 0;
               end else begin
                  m_t++;
               end
            end else if (enable_i) begin
               m_run = 1'b1;
               m_t   = 0;
            end
         end
      end
   end

   // ---------------- pixel source: one slot per ready pulse ----------------
   logic [15:0] src [8] = '{16'h1234, 16'hABCD, 16'h0F0F, 16'hF0F0,
                            16'h5A5A, 16'h00FF, 16'h8001, 16'h7E7E};
   int slot = 0;
   int drop_slot = -1;
   int rdy_cnt = 0;

   initial forever begin : source
      bit rdy_seen, fs_seen;
      @(negedge clk);
      rdy_seen = s_ready_o;
      fs_seen  = frame_start_o;
      @(posedge clk);
      #1;
      if (fs_seen) begin
         slot = 0; rdy_cnt = 0;
      end else if (rdy_seen) begin
         slot++; rdy_cnt++;
      end
      s_data_i  = src[slot % 8];
      s_valid_i = (slot != drop_slot);
   end

   // ---------------- receiver sampling on pclk rising ----------------
   int         vs_cnt = 0;
   int         href_cnt = 0;
   int         runs = 0;
   bit         rx_vs = 1'b0;
   bit         rx_hr = 1'b0;
   logic [7:0] rx_q [$];

   initial forever begin
      @(posedge pclk_o);
      if (vsync_o && !rx_vs) begin
         vs_cnt = 0; href_cnt = 0; runs = 0; rx_q.delete();
      end
      if (vsync_o) vs_cnt++;
      if (href_o) begin
         if (!rx_hr) runs++;
         href_cnt++;
         rx_q.push_back(cam_data_o);
      end
      rx_vs = vsync_o;
      rx_hr = href_o;
   end

   logic [7:0] exp_n [8] = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h0F, 8'h0F, 8'hF0, 8'hF0};
   logic [7:0] exp_u [8] = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h0F, 8'h0F, 8'hF0, 8'hF0};

   task automatic chk_frame(input bit unr);
      logic [31:0] a;
      chk("vs_periods", vs_cnt, 11);
      chk("href_periods", href_cnt, 16);
      chk("href_lines", runs, 2);
      chk("ready_pulses", rdy_cnt, 8);
      for (int i = 0; i < 8; i++) begin
         a = (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF;
         chk($sformatf("byte%0d", i), a, unr ? exp_u[i] : exp_n[i]);
      end
   endtask

   task automatic wait_fs(input int limit, output int at);
      bit got = 1'b0;
      for (int i = 0; i < limit && !got; i++) begin
         @(negedge clk);
         got = frame_start_o;
      end
      at = cyc;
      chk("fs_seen", got, 1);
      #2;
   endtask

   initial begin : main
      int t0, t1, t2, t3, t4, t5, t6, nfs, npclk, nbusy;
      bit got;
      repeat (3) @(posedge clk);
      #1 arm = 1'b1;
      @(negedge clk);
      chk("rst_busy", busy_o, 0);
      chk("rst_pclk", pclk_o, 0);
      @(posedge clk);
      #1 sys_rst_i = 1'b0;
      enable_i = 1'b1;

      // timing, data order and back-to-back frames
      wait_fs(20, t0);
      wait_fs(FC + 10, t1);
      chk("frame_len", t1 - t0, 110);
      chk_frame(1'b0);
      wait_fs(FC + 10, t2);
      chk("b2b_len1", t2 - t1, 110);
      chk_frame(1'b0);
      chk("no_underrun", underrun_o, 0);

      // underrun on the second pixel of the next frame
      drop_slot = 1;
      wait_fs(FC + 10, t3);
      chk("b2b_len2", t3 - t2, 110);
      chk_frame(1'b1);
      chk("underrun_set", underrun_o, 1);
      drop_slot = -1;

      // stop: drop enable during the second active line
      repeat (2 * (3 * LL + 2)) @(negedge clk);
      chk("stop_in_href", href_o, 1);
      @(posedge clk);
      #1 enable_i = 1'b0;
      got = 1'b0;
      for (int i = 0; i < FC && !got; i++) begin
         @(negedge clk);
         got = !busy_o;
      end
      chk("stop_len", cyc - t3, 110);
      chk("stop_href", href_cnt, 16);
      nfs = 0; npclk = 0; nbusy = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         nfs   += int'(frame_start_o);
         npclk += int'(pclk_o);
         nbusy += int'(busy_o);
      end
      chk("idle_fs", nfs, 0);
      chk("idle_pclk", npclk, 0);
      chk("idle_busy", nbusy, 0);
      chk("underrun_sticky", underrun_o, 1);

      // reset in the middle of href
      @(posedge clk);
      #1 enable_i = 1'b1;
      wait_fs(20, t4);
      got = 1'b0;
      for (int i = 0; i < FC && !got; i++) begin
         @(negedge clk);
         got = href_o;
      end
      chk("reset_in_href", href_o, 1);
      @(posedge clk);
      #1 sys_rst_i = 1'b1;
      @(posedge clk);
      #1 sys_rst_i = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", busy_o, 0);
      chk("mid_rst_vsync", vsync_o, 0);
      chk("mid_rst_href", href_o, 0);
      chk("mid_rst_data", cam_data_o, 0);
      chk("mid_rst_pclk", pclk_o, 0);
      chk("mid_rst_ready", s_ready_o, 0);
      chk("mid_rst_underrun", underrun_o, 0);
      chk("mid_rst_fs", frame_start_o, 0);
      wait_fs(5, t5);
      wait_fs(FC + 10, t6);
      chk("post_rst_len", t6 - t5, 110);
      chk_frame(1'b0);
      enable_i = 1'b0;
      repeat (FC + 10) @(negedge clk);
      chk("final_idle", busy_o, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
